// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between eight bus requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;

  modport master (output req, input gnt, input sel, input bus_valid);
  modport slave  (input req, output gnt, output sel, output bus_valid);
endinterface

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for the 8-input, 16-bit operand/result bus with a hold limit
// that forces rotation while other requesters wait. Outputs decode from registers only.
module bus_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic           clk,
  input logic           rst_n,
  bus_arbiter8_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]      others;

  // First set bit of mask scanning start, start+1, ... with wrap-around.
  function automatic logic [2:0] rr_next(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_next = start;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    others     = bus.req & ~(8'b1 << owner_q);
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d    = StGrant;
          owner_d    = rr_next(bus.req, owner_q + 3'd1);
          hold_cnt_d = CntW'(1);
        end
      end
      StGrant: begin
        if (|others && (!bus.req[owner_q] || hold_cnt_q == HoldMax)) begin
          owner_d    = rr_next(others, owner_q + 3'd1);
          hold_cnt_d = CntW'(1);
        end else if (!bus.req[owner_q]) begin
          // owner_q is kept as the round-robin pointer while idle
          state_d = StIdle;
        end else if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= 3'd7;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.bus_valid = (state_q == StGrant);
  assign bus.gnt       = bus.bus_valid ? (8'b1 << owner_q) : 8'h00;
  assign bus.sel       = bus.bus_valid ? owner_q : 3'd0;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Scoreboard bench for bus_arbiter8: directed scenarios plus random requests, each
// checked against a pointer/tenure reference model of the round-robin rules.
module tb_bus_arbiter8;

  localparam int unsigned MaxHold = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bus_arbiter8_if bus ();

  bus_arbiter8 #(.MAX_HOLD(MaxHold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner index (-1 when idle), search pointer, cycles of tenure.
  int m_owner  = -1;
  int m_ptr    = 7;
  int m_tenure = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, required);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] mask, input int start);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 7;
    m_tenure = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner  = rr_pick(r, m_ptr + 1);
        m_ptr    = m_owner;
        m_tenure = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (others != 8'h00 && (!r[m_owner] || m_tenure >= int'(MaxHold))) begin
        m_owner  = rr_pick(others, m_owner + 1);
        m_ptr    = m_owner;
        m_tenure = 1;
      end else if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_tenure < int'(MaxHold)) begin
        m_tenure++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    if (m_owner < 0) begin
      e = '0;
    end else begin
      e.gnt   = 8'h00;
      e.gnt[m_owner] = 1'b1;
      e.sel   = 3'(m_owner);
      e.valid = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle of requests and queue the response expected after the next edge.
  task automatic drive(input logic [7:0] r);
    @(negedge clk);
    bus.req = r;
    model_step(r);
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = 8'h00;
    rst_n   = 1'b0;
    #1;
    check("async_reset_gnt", int'(bus.gnt), 0);
    check("async_reset_valid", int'(bus.bus_valid), 0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(model_out());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every registered output update against the scoreboard.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt", int'(bus.gnt), int'(e.gnt));
      check("sel", int'(bus.sel), int'(e.sel));
      check("bus_valid", int'(bus.bus_valid), int'(e.valid));
      check("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
    end
  end

  initial begin
    logic [7:0] cur;
    bus.req = 8'h00;

    do_reset();
    repeat (5) drive(8'h00);

    // Single requester, then release.
    repeat (10) drive(8'h20);
    repeat (2) drive(8'h00);

    // Reset mid-grant.
    repeat (3) drive(8'h20);
    do_reset();

    // All eight continuously.
    repeat (40) drive(8'hFF);

    // Round-robin pointer: 3 alone, release, then 0 and 3.
    do_reset();
    repeat (3) drive(8'h08);
    drive(8'h00);
    repeat (2) drive(8'h09);
    repeat (3) drive(8'h08);
    drive(8'h00);

    // Forced switch between 6 and 2.
    do_reset();
    drive(8'h40);
    repeat (12) drive(8'h44);
    drive(8'h00);

    // Early withdrawal of 1 while 4 owns the bus.
    do_reset();
    drive(8'h10);
    drive(8'h12);
    repeat (6) drive(8'h10);
    drive(8'h00);

    // Random requests; mostly held levels so tenures reach the limit.
    cur = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur = ($urandom_range(0, 1) == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      end
      if (n == 200) do_reset();
      drive(cur);
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
